// File: rtl/avr_io_pkg.sv
// Shared I/O-bus constants for the AVR-style peripherals: GPIO register
// offsets and pin-change control bit positions.
package avr_io_pkg;

  localparam logic [2:0] GPIO_PIN_OFS   = 3'd0;
  localparam logic [2:0] GPIO_DDR_OFS   = 3'd1;
  localparam logic [2:0] GPIO_PORT_OFS  = 3'd2;
  localparam logic [2:0] GPIO_PCMSK_OFS = 3'd3;
  localparam logic [2:0] GPIO_PCCR_OFS  = 3'd4;
  localparam logic [6:0] GPIO_SPAN      = 7'd5;

  localparam int PCIF_BIT = 0;
  localparam int PCIE_BIT = 1;

endpackage

// File: rtl/avr_sync_bits.sv
// Multi-flop synchroniser for asynchronous inputs, WIDTH bits by STAGES deep,
// asynchronous active-low reset to 0.
module avr_sync_bits #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/avr_gpio_pcint.sv
// AVR-style GPIO port with PIN-write toggle and synchronised inputs.
// Define AVR_GPIO_PCINT_EN to add PCMSK/PCCR and the masked pin-change irq.
module avr_gpio_pcint
  import avr_io_pkg::*;
#(
  parameter int IO_ADDR     = 0,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            io_addr,
  inout  wire  [7:0]            io_data,
  input  logic                  io_write,
  input  logic                  io_read,
  output logic                  irq,
  input  logic                  irq_ack,
  inout  wire  [PORT_WIDTH-1:0] gpio
);

  // Bus handshake: a read is valid while io_read is high and the address
  // decodes; data is returned combinationally in that same cycle. A write
  // commits on the edge where io_write is high. There is no back-pressure.
  logic [6:0]            ofs_full;
  logic [2:0]            ofs;
  logic                  hit;
  logic                  wr_en;
  logic                  rd_en;
  logic [PORT_WIDTH-1:0] wdata;
  logic [7:0]            rd_data;
  logic                  unused_ok;

  // Widened subtract: addresses below IO_ADDR wrap high and never hit.
  assign ofs_full  = {1'b0, io_addr} - 7'(IO_ADDR);
  assign hit       = ofs_full < GPIO_SPAN;
  assign ofs       = ofs_full[2:0];
  assign wr_en     = io_write & hit;
  assign rd_en     = io_read & hit;
  assign wdata     = io_data[PORT_WIDTH-1:0];
  assign unused_ok = ^{io_data, irq_ack};

  logic [PORT_WIDTH-1:0] ddr_q, ddr_d;
  logic [PORT_WIDTH-1:0] port_q, port_d;
  logic [PORT_WIDTH-1:0] pin_sync;

  always_comb begin
    ddr_d  = ddr_q;
    port_d = port_q;
    if (wr_en) begin
      case (ofs)
        GPIO_PIN_OFS:  port_d = port_q ^ wdata;
        GPIO_DDR_OFS:  ddr_d  = wdata;
        GPIO_PORT_OFS: port_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_q  <= '0;
      port_q <= '0;
    end else begin
      ddr_q  <= ddr_d;
      port_q <= port_d;
    end
  end

  for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pad
    assign gpio[i] = ddr_q[i] ? port_q[i] : 1'bz;
  end

  // Pads are always sampled, so output pins read back what they drive.
  avr_sync_bits #(
    .WIDTH  (PORT_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gpio),
    .q_o   (pin_sync)
  );

`ifdef AVR_GPIO_PCINT_EN
  logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic [PORT_WIDTH-1:0] pin_prev_q;
  logic [PORT_WIDTH-1:0] chg;
  logic                  pcif_q, pcif_d;
  logic                  pcie_q, pcie_d;
  logic                  pcif_clr;

  assign chg      = (pin_sync ^ pin_prev_q) & pcmsk_q;
  assign pcif_clr = irq_ack | (wr_en && (ofs == GPIO_PCCR_OFS) && io_data[PCIF_BIT]);

  always_comb begin
    pcmsk_d = pcmsk_q;
    pcie_d  = pcie_q;
    if (wr_en && (ofs == GPIO_PCMSK_OFS)) pcmsk_d = wdata;
    if (wr_en && (ofs == GPIO_PCCR_OFS))  pcie_d  = io_data[PCIE_BIT];
    // A fresh change wins over a same-cycle clear so no event is lost.
    if (|chg)         pcif_d = 1'b1;
    else if (pcif_clr) pcif_d = 1'b0;
    else              pcif_d = pcif_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcmsk_q    <= '0;
      pin_prev_q <= '0;
      pcif_q     <= 1'b0;
      pcie_q     <= 1'b0;
    end else begin
      pcmsk_q    <= pcmsk_d;
      pin_prev_q <= pin_sync;
      pcif_q     <= pcif_d;
      pcie_q     <= pcie_d;
    end
  end

  assign irq = pcif_q & pcie_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (ofs)
      GPIO_PIN_OFS:   rd_data = 8'(pin_sync);
      GPIO_DDR_OFS:   rd_data = 8'(ddr_q);
      GPIO_PORT_OFS:  rd_data = 8'(port_q);
`ifdef AVR_GPIO_PCINT_EN
      GPIO_PCMSK_OFS: rd_data = 8'(pcmsk_q);
      GPIO_PCCR_OFS: begin
        rd_data[PCIF_BIT] = pcif_q;
        rd_data[PCIE_BIT] = pcie_q;
      end
`endif
      default: ;
    endcase
  end

  assign io_data = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_avr_gpio_pcint.sv
// Self-checking bench for avr_gpio_pcint: directed bus/pad stimulus with a
// scoreboard queue popped by a negedge monitor.
module tb_avr_gpio_pcint;

  localparam int SS  = 2;
  localparam int SS4 = 3;
`ifdef AVR_GPIO_PCINT_EN
  localparam bit PCI = 1'b1;
`else
  localparam bit PCI = 1'b0;
`endif

  localparam logic [5:0] A_PIN   = 6'd0;
  localparam logic [5:0] A_DDR   = 6'd1;
  localparam logic [5:0] A_PORT  = 6'd2;
  localparam logic [5:0] A_PCMSK = 6'd3;
  localparam logic [5:0] A_PCCR  = 6'd4;
  localparam logic [5:0] B4      = 6'd8;

  localparam logic [1:0] K_BUS  = 2'd0;
  localparam logic [1:0] K_IRQ  = 2'd1;
  localparam logic [1:0] K_GPIO = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] mask;
    string      name;
  } meta_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] io_addr;
  logic       io_write, io_read, irq_ack, probe_req;
  logic       tb_bus_en;
  logic [7:0] tb_bus_val;
  logic [7:0] pad_en, pad_val;
  logic       irq, irq4;
  wire  [7:0] io_data;
  wire  [7:0] gpio;
  wire  [3:0] gpio4;

  logic [7:0] exp_q[$];
  meta_t      meta_q[$];
  int         checks = 0;
  int         failures = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  assign io_data = tb_bus_en ? tb_bus_val : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign gpio[i] = pad_en[i] ? pad_val[i] : 1'bz;
  end

  avr_gpio_pcint #(.IO_ADDR(0), .PORT_WIDTH(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_data(io_data),
    .io_write(io_write), .io_read(io_read), .irq(irq), .irq_ack(irq_ack),
    .gpio(gpio)
  );

  avr_gpio_pcint #(.IO_ADDR(8), .PORT_WIDTH(4), .SYNC_STAGES(SS4)) dut4 (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_data(io_data),
    .io_write(io_write), .io_read(io_read), .irq(irq4), .irq_ack(irq_ack),
    .gpio(gpio4)
  );

  // Driver tasks: entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    io_addr = a; tb_bus_val = d; tb_bus_en = 1'b1; io_write = 1'b1;
    @(posedge clk); #1;
    io_write = 1'b0; tb_bus_en = 1'b0;
  endtask

  task automatic read_chk(input logic [5:0] a, input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    meta_q.push_back('{kind: K_BUS, mask: 8'hFF, name: nm});
    io_addr = a; io_read = 1'b1;
    @(posedge clk); #1;
    io_read = 1'b0;
  endtask

  task automatic probe(input logic [1:0] k, input logic [7:0] e, input logic [7:0] m,
                       input string nm);
    exp_q.push_back(e & m);
    meta_q.push_back('{kind: k, mask: m, name: nm});
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (io_read || probe_req) begin
      logic [7:0] e, act;
      meta_t      m;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: DUT output with nothing expected");
      end else begin
        e = exp_q.pop_front();
        m = meta_q.pop_front();
        case (m.kind)
          K_IRQ:   act = {7'd0, irq};
          K_GPIO:  act = gpio & m.mask;
          default: act = io_data;
        endcase
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", m.name, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; io_addr = '0; io_write = 1'b0; io_read = 1'b0; irq_ack = 1'b0;
    probe_req = 1'b0; tb_bus_en = 1'b0; tb_bus_val = '0;
    pad_en = 8'hFF; pad_val = 8'hA5;
    @(posedge clk); #1;
    idle(3);
    rst_n = 1'b1;
    idle(SS + 3);

    // Load registers, then reset in the middle of a DDR write.
    bus_write(A_PORT, 8'hFF);
    bus_write(A_PCMSK, 8'hFF);
    bus_write(A_PCCR, 8'h02);
    io_addr = A_DDR; tb_bus_val = 8'hFF; tb_bus_en = 1'b1; io_write = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    io_write = 1'b0; tb_bus_en = 1'b0;
    read_chk(A_DDR,   8'h00, "rst_ddr");
    read_chk(A_PORT,  8'h00, "rst_port");
    read_chk(A_PCMSK, 8'h00, "rst_pcmsk");
    read_chk(A_PCCR,  8'h00, "rst_pccr");
    read_chk(A_PIN,   8'h00, "rst_pin");
    probe(K_IRQ,  8'h00, 8'h01, "rst_irq");
    probe(K_GPIO, 8'hA5, 8'hFF, "rst_pads_z");
    rst_n = 1'b1;
    idle(SS - 1);
    read_chk(A_PIN, 8'h00, "pin_before_sync");
    read_chk(A_PIN, 8'hA5, "pin_after_sync");
    probe(K_IRQ, 8'h00, 8'h01, "irq_after_release");

    // Direction / output: bench drives 0 on the upper nibble only.
    pad_en = 8'hF0; pad_val = 8'h00;
    bus_write(A_DDR, 8'h0F);
    bus_write(A_PORT, 8'h3C);
    probe(K_GPIO, 8'h0C, 8'h0F, "pads_low_nibble");
    read_chk(A_DDR,  8'h0F, "ddr_rd");
    read_chk(A_PORT, 8'h3C, "port_rd");
    idle(SS - 2);
    read_chk(A_PIN, 8'h0C, "pin_mixed");

    // Toggle through PIN
    bus_write(A_PIN, 8'hFF);
    read_chk(A_PORT, 8'hC3, "toggle_port");
    probe(K_GPIO, 8'h03, 8'h0F, "toggle_pads");

    // Bus isolation: bench holds 00 on the bus; any DUT drive would show.
    tb_bus_en = 1'b1; tb_bus_val = 8'h00;
    read_chk(6'd5, 8'h00, "iso_addr5");
    io_addr = A_PORT;
    probe(K_BUS, 8'h00, 8'hFF, "iso_no_read");
    tb_bus_en = 1'b0;

    // Narrow instance
    bus_write(B4 + A_DDR, 8'hFF);
    read_chk(B4 + A_DDR, 8'h0F, "w4_ddr");
    bus_write(B4 + A_PORT, 8'h5A);
    read_chk(B4 + A_PORT, 8'h0A, "w4_port");
    idle(SS4 - 1);
    read_chk(B4 + A_PIN, 8'h0A, "w4_pin");

    // Pin-change interrupt
    bus_write(A_DDR, 8'h00);
    pad_en = 8'hFF; pad_val = 8'h00;
    idle(SS + 2);
    bus_write(A_PCMSK, 8'h01);
    bus_write(A_PCCR, 8'h02);
    read_chk(A_PCMSK, PCI ? 8'h01 : 8'h00, "pcmsk_rd");
    read_chk(A_PCCR,  PCI ? 8'h02 : 8'h00, "pccr_pcie");
    pad_val[0] = 1'b1;
    idle(SS);
    probe(K_IRQ, 8'h00, 8'h01, "irq_not_early");
    probe(K_IRQ, {7'd0, PCI}, 8'h01, "irq_on_time");
    read_chk(A_PCCR, PCI ? 8'h03 : 8'h00, "pccr_pcif");
    bus_write(A_PCCR, 8'h03);
    probe(K_IRQ, 8'h00, 8'h01, "irq_w1c");
    read_chk(A_PCCR, PCI ? 8'h02 : 8'h00, "pccr_after_w1c");
    pad_val[1] = 1'b1;
    idle(SS + 1);
    probe(K_IRQ, 8'h00, 8'h01, "irq_unmasked_pin");

    // Set beats clear: ack lands on the detection cycle.
    pad_val[0] = 1'b0;
    idle(SS);
    ack_pulse();
    probe(K_IRQ, {7'd0, PCI}, 8'h01, "set_beats_ack");
    read_chk(A_PCCR, PCI ? 8'h03 : 8'h00, "pccr_set_beats_ack");
    ack_pulse();
    probe(K_IRQ, 8'h00, 8'h01, "irq_ack_clears");
    read_chk(A_PCCR, PCI ? 8'h02 : 8'h00, "pccr_after_ack");

    idle(2);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
